// File: rtl/bambu_mem_responder.sv
// Slave end of the Bambu Mout/M memory protocol: byte-addressed loads/stores with preload port.
// Latency READ_DELAY/WRITE_DELAY cycles to the M_DataRdy pulse; no backpressure, requests are ignored while busy.
module bambu_mem_responder #(
    parameter int                      BITSIZE_addr = 32,
    parameter int                      BITSIZE_data = 32,
    parameter int                      BITSIZE_size = 6,
    parameter int                      MEM_BYTES    = 1024,
    parameter logic [BITSIZE_addr-1:0] BASE_ADDR    = '0,
    parameter int                      READ_DELAY   = 2,
    parameter int                      WRITE_DELAY  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    Mout_oe_ram,
    input  logic                    Mout_we_ram,
    input  logic [BITSIZE_addr-1:0] Mout_addr_ram,
    input  logic [BITSIZE_data-1:0] Mout_Wdata_ram,
    input  logic [BITSIZE_size-1:0] Mout_data_ram_size,
    output logic [BITSIZE_data-1:0] M_Rdata_ram,
    output logic                    M_DataRdy,
    input  logic                    ld_en,
    input  logic [BITSIZE_addr-1:0] ld_addr,
    input  logic [7:0]              ld_byte,
    output logic                    busy,
    output logic                    oor_err,
    output logic                    proto_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW    = 16;

    logic [1:0]              state;
    logic [CW-1:0]           cnt;
    logic                    q_wr;
    logic                    q_oor;
    logic [2:0]              q_bytes;
    logic [IDX_W-1:0]        q_off;
    logic [BITSIZE_data-1:0] q_wdata;

    logic [7:0] mem [MEM_BYTES];

    logic                    idle;
    logic                    req;
    logic                    size_bad;
    logic [2:0]              in_bytes;
    logic [BITSIZE_addr-1:0] in_off;
    logic [BITSIZE_addr:0]   in_end;
    logic                    in_oor;
    logic [CW-1:0]           in_delay;
    logic                    cur_wr;
    logic                    cur_oor;
    logic [2:0]              cur_bytes;
    logic [IDX_W-1:0]        cur_off;
    logic [BITSIZE_data-1:0] cur_wdata;
    logic                    go_done;
    logic                    pre_wr;
    logic [BITSIZE_data-1:0] rd_word;

    always_comb begin
        idle     = (state == S_IDLE);
        req      = Mout_oe_ram | Mout_we_ram;
        size_bad = 1'b0;
        case (Mout_data_ram_size)
            BITSIZE_size'(8):  in_bytes = 3'd1;
            BITSIZE_size'(16): in_bytes = 3'd2;
            BITSIZE_size'(32): in_bytes = 3'd4;
            default: begin
                in_bytes = 3'd4;
                size_bad = 1'b1;
            end
        endcase
        in_off   = Mout_addr_ram - BASE_ADDR;
        in_end   = {1'b0, in_off} + (BITSIZE_addr + 1)'(in_bytes);
        in_oor   = (Mout_addr_ram < BASE_ADDR) || (in_end > (BITSIZE_addr + 1)'(MEM_BYTES));
        in_delay = Mout_we_ram ? CW'(WRITE_DELAY) : CW'(READ_DELAY);
    end

    // In IDLE a delay-1 access completes on the accepting edge, so it uses the live inputs.
    always_comb begin
        cur_wr    = idle ? Mout_we_ram    : q_wr;
        cur_oor   = idle ? in_oor         : q_oor;
        cur_bytes = idle ? in_bytes       : q_bytes;
        cur_off   = idle ? in_off[IDX_W-1:0] : q_off;
        cur_wdata = idle ? Mout_Wdata_ram : q_wdata;
        go_done   = (idle && req && in_delay == CW'(1)) ||
                    (state == S_WAIT && cnt == CW'(1));
        pre_wr    = idle && ld_en && !req && (ld_addr < BITSIZE_addr'(MEM_BYTES));
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(cur_bytes)) begin
                rd_word[8*i +: 8] = mem[cur_off + IDX_W'(i)];
            end
        end
    end

    // Array is never cleared; writes are gated while reset is held so an aborted store never lands.
    always_ff @(posedge clock) begin
        if (reset && go_done && cur_wr && !cur_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(cur_bytes)) begin
                    mem[cur_off + IDX_W'(i)] <= cur_wdata[8*i +: 8];
                end
            end
        end
        if (reset && pre_wr) begin
            mem[ld_addr[IDX_W-1:0]] <= ld_byte;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            q_wr        <= 1'b0;
            q_oor       <= 1'b0;
            q_bytes     <= '0;
            q_off       <= '0;
            q_wdata     <= '0;
            M_DataRdy   <= 1'b0;
            M_Rdata_ram <= '0;
            oor_err     <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            M_DataRdy   <= go_done;
            M_Rdata_ram <= (go_done && !cur_wr && !cur_oor) ? rd_word : '0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        q_wr    <= Mout_we_ram;
                        q_oor   <= in_oor;
                        q_bytes <= in_bytes;
                        q_off   <= in_off[IDX_W-1:0];
                        q_wdata <= Mout_Wdata_ram;
                        cnt     <= in_delay - CW'(1);
                        state   <= (in_delay == CW'(1)) ? S_DONE : S_WAIT;
                        if (in_oor) oor_err <= 1'b1;
                        if (size_bad || (Mout_oe_ram && Mout_we_ram)) proto_err <= 1'b1;
                    end
                    if (ld_en) begin
                        if (req) proto_err <= 1'b1;
                        else if (ld_addr >= BITSIZE_addr'(MEM_BYTES)) oor_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_DONE;
                    if (ld_en) proto_err <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (ld_en) proto_err <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_bambu_mem_responder.sv
// Scoreboard bench: driver pushes expected completions from a byte-array model, monitor pops on M_DataRdy.
module tb_bambu_mem_responder;
    localparam int          MEM  = 1024;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          RD   = 2;
    localparam int          WD   = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        oe = 1'b0, we = 1'b0, ld_en = 1'b0;
    logic [31:0] addr = '0, wdata = '0, ld_addr = '0;
    logic [5:0]  size = 6'd32;
    logic [7:0]  ld_byte = '0;
    logic [31:0] rdata;
    logic        rdy, busy, oor_err, proto_err;

    logic        r1_reset = 1'b0, r1_oe = 1'b0, r1_we = 1'b0, r1_ld_en = 1'b0;
    logic [31:0] r1_addr = '0, r1_wdata = '0, r1_ld_addr = '0;
    logic [5:0]  r1_size = 6'd8;
    logic [7:0]  r1_ld_byte = '0;
    logic [31:0] r1_rdata;
    logic        r1_rdy, r1_busy, r1_oor, r1_proto;

    always #5 clock = ~clock;

    bambu_mem_responder #(.MEM_BYTES(MEM), .BASE_ADDR(BASE), .READ_DELAY(RD), .WRITE_DELAY(WD)) u0 (
        .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size), .M_Rdata_ram(rdata), .M_DataRdy(rdy),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_byte(ld_byte), .busy(busy), .oor_err(oor_err),
        .proto_err(proto_err));

    bambu_mem_responder #(.READ_DELAY(4), .WRITE_DELAY(3)) u1 (
        .clock(clock), .reset(r1_reset), .Mout_oe_ram(r1_oe), .Mout_we_ram(r1_we), .Mout_addr_ram(r1_addr),
        .Mout_Wdata_ram(r1_wdata), .Mout_data_ram_size(r1_size), .M_Rdata_ram(r1_rdata), .M_DataRdy(r1_rdy),
        .ld_en(r1_ld_en), .ld_addr(r1_ld_addr), .ld_byte(r1_ld_byte), .busy(r1_busy), .oor_err(r1_oor),
        .proto_err(r1_proto));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          cyc;
        bit          is_load;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m [MEM];
    bit mdl_oor   = 1'b0;
    bit mdl_proto = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] mdl_access(bit wr, logic [31:0] a, logic [5:0] sz, logic [31:0] wd);
        int nb;
        longint off;
        logic [31:0] r = '0;
        case (sz)
            6'd8:    nb = 1;
            6'd16:   nb = 2;
            6'd32:   nb = 4;
            default: begin nb = 4; mdl_proto = 1'b1; end
        endcase
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        if (off < 0 || off + nb > MEM) begin
            mdl_oor = 1'b1;
            return '0;
        end
        for (int i = 0; i < nb; i++) begin
            if (wr) m[int'(off) + i] = wd[8*i +: 8];
            else    r[8*i +: 8] = m[int'(off) + i];
        end
        return r;
    endfunction

    // Monitor: every completion must match the oldest expectation in cycle and data.
    always @(negedge clock) begin
        if (mon_en) begin
            if (rdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdy", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdy_cycle", cyc, e.cyc);
                    if (e.is_load) chk("load_data", rdata, e.data);
                end
            end else begin
                chk("rdata_idle_zero", rdata, 0);
            end
        end
    end

    task automatic do_preload(input logic [31:0] off, input logic [7:0] b);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = off; ld_byte = b;
        if (off < MEM) m[off] = b;
        else mdl_oor = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            oe = 1'b0; we = 1'b0; ld_en = 1'b0;
        end
    endtask

    task automatic do_req(input bit o, input bit w, input logic [31:0] a, input logic [5:0] sz,
                          input logic [31:0] wd, input bit ld_wait);
        int d;
        exp_t e;
        @(negedge clock);
        oe = o; we = w; addr = a; size = sz; wdata = wd; ld_en = 1'b0;
        d = w ? WD : RD;
        if (o && w) mdl_proto = 1'b1;
        e.cyc = cyc + d;
        e.is_load = !w;
        e.data = mdl_access(w, a, sz, wd);
        sb.push_back(e);
        if (ld_wait) mdl_proto = 1'b1;
        for (int i = 0; i < d; i++) begin
            @(negedge clock);
            oe = 1'b0; we = 1'b0;
            ld_en = ld_wait && (i == 0);
        end
        ld_en = 1'b0;
    endtask

    task automatic do_held(input logic [31:0] a);
        exp_t e;
        bit pat [6] = '{0, 1, 1, 0, 1, 1};
        @(negedge clock);
        oe = 1'b1; we = 1'b0; addr = a; size = 6'd32; ld_en = 1'b0;
        chk("held_busy0", busy, pat[0]);
        e.is_load = 1'b1;
        e.data = mdl_access(1'b0, a, 6'd32, '0);
        e.cyc = cyc + 2; sb.push_back(e);
        e.cyc = cyc + 5; sb.push_back(e);
        for (int i = 1; i < 6; i++) begin
            @(negedge clock);
            if (i == 4) oe = 1'b0;
            chk("held_busy", busy, pat[i]);
        end
    endtask

    initial begin
        int got_cyc;
        logic [31:0] got_dat;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {rdy, rdata, busy, oor_err, proto_err}, 0);
        reset = 1'b1; r1_reset = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < MEM; i++) do_preload(i, 8'($urandom));
        idle(1);

        // Preload and read
        do_preload(0, 8'h11); do_preload(1, 8'h22); do_preload(2, 8'h33); do_preload(3, 8'h44);
        do_req(1, 0, BASE, 6'd32, '0, 0);
        chk("preload_model", mdl_access(1'b0, BASE, 6'd32, '0), 32'h4433_2211);

        // Store then load in the cycle after DONE
        do_preload(8, 8'h00); do_preload(9, 8'h00);
        do_req(0, 1, BASE + 6, 6'd16, 32'hDEAD_BEEF, 0);
        do_req(1, 0, BASE + 6, 6'd32, '0, 0);

        do_held(BASE);

        // Range errors
        chk("oor_before", oor_err, 0);
        do_req(1, 0, BASE + MEM - 2, 6'd32, '0, 0);
        do_req(0, 1, BASE - 1, 6'd32, 32'hCAFE_F00D, 0);
        do_req(1, 0, BASE, 6'd32, '0, 0);
        do_req(1, 0, BASE + MEM - 2, 6'd16, '0, 0);
        idle(1);
        chk("oor_after", oor_err, 1);

        // Protocol errors
        chk("proto_before", proto_err, 0);
        do_req(1, 1, BASE + 20, 6'd24, 32'h1234_5678, 0);
        ld_addr = 40; ld_byte = 8'h5A;
        do_req(1, 0, BASE + 48, 6'd32, '0, 1);
        do_req(1, 0, BASE + 20, 6'd32, '0, 0);
        do_req(1, 0, BASE + 40, 6'd8, '0, 0);
        idle(1);
        chk("proto_after", proto_err, 1);

        for (int n = 0; n < 80; n++) begin
            int r;
            logic [31:0] a;
            logic [5:0] sz;
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 6'd8 : (r < 6) ? 6'd16 : 6'd32;
            a = ($urandom_range(0, 9) < 8) ? BASE + $urandom_range(0, 31) : BASE + $urandom_range(0, MEM + 8);
            if (r == 0) do_preload($urandom_range(0, 31), 8'($urandom));
            else do_req(r[0], ~r[0], a, sz, $urandom, 0);
        end
        idle(4);
        chk("sb_empty", sb.size(), 0);
        chk("oor_final", oor_err, mdl_oor);
        chk("proto_final", proto_err, mdl_proto);

        // Reset mid-store on the long-latency instance
        @(negedge clock);
        r1_ld_en = 1'b1; r1_ld_addr = 5; r1_ld_byte = 8'h3C;
        @(negedge clock);
        r1_ld_en = 1'b0; r1_we = 1'b1; r1_addr = 5; r1_size = 6'd8; r1_wdata = 32'hA5;
        @(negedge clock);
        r1_we = 1'b0;
        chk("r1_busy_wait", r1_busy, 1);
        r1_reset = 1'b0;
        #1;
        chk("r1_reset_outputs", {r1_rdy, r1_rdata, r1_busy, r1_oor, r1_proto}, 0);
        repeat (2) @(negedge clock);
        r1_reset = 1'b1;
        got_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (r1_rdy) got_cyc++;
        end
        chk("r1_no_rdy_after_reset", got_cyc, 0);
        @(negedge clock);
        r1_oe = 1'b1; r1_addr = 5; r1_size = 6'd8;
        got_cyc = -1; got_dat = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            r1_oe = 1'b0;
            if (r1_rdy && got_cyc < 0) begin got_cyc = i; got_dat = r1_rdata; end
        end
        chk("r1_load_cycle", got_cyc, 4);
        chk("r1_load_old_value", got_dat, 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
